// File: rtl/vga_image_scanout.sv
// ---------------------------------------------------------------------------
// vga_image_scanout
//
// Pixel-fetch and colour stage behind the 640x480 VGA sync generator.
// Fetches grayscale pixels of the filtered image from a double-banked frame
// RAM, replicates them 2^SCALE_LOG2 times in x and y, centres the window on
// screen and drives RGB plus syncs aligned with latency L = RAM_LAT + 2.
// Also owns the front/back bank swap handshake with the frame writer; the
// front bank only changes on a vsync falling edge, so frames never tear.
//
// Optional feature macro: SCANOUT_BORDER_EN
//   defined   : one-pixel white ring drawn just outside the image window
//   undefined : ring pixels stay black, no border logic
//
// Ports
//   pclk, rst_n              pixel clock, async active-low reset
//   in_hsync, in_vsync       active-low syncs from the sync generator
//   in_active, in_x, in_y    visible flag and coordinates (aligned)
//   frame_ready              writer finished a frame in the back bank (pulse)
//   wr_ready, wr_bank        writer may fill back bank wr_bank
//   rd_en, rd_bank, rd_addr  frame RAM read port (registered)
//   rd_data                  pixel, valid RAM_LAT cycles after rd_en
//   vga_r/g/b, vga_h/vsync   VGA pin outputs (registered)
//   bank_swapped             one-cycle pulse when the front bank toggles
//   dbg_bank_state           bank FSM state (0 = IDLE, 1 = PENDING)
//
// Handshake: frame_ready is accepted only while wr_ready=1; once accepted,
// wr_ready stays low until the swap at the next vsync falling edge.
// ---------------------------------------------------------------------------
module vga_image_scanout #(
    parameter int IMG_W      = 128,
    parameter int IMG_H      = 128,
    parameter int SCALE_LOG2 = 1,
    parameter int X0         = 192,
    parameter int Y0         = 112,
    parameter int ADDR_W     = 14,
    parameter int RAM_LAT    = 1
) (
    input  logic              pclk,
    input  logic              rst_n,
    input  logic              in_hsync,
    input  logic              in_vsync,
    input  logic              in_active,
    input  logic [9:0]        in_x,
    input  logic [8:0]        in_y,
    input  logic              frame_ready,
    output logic              wr_ready,
    output logic              wr_bank,
    output logic              rd_en,
    output logic              rd_bank,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    output logic [3:0]        vga_r,
    output logic [3:0]        vga_g,
    output logic [3:0]        vga_b,
    output logic              vga_hsync,
    output logic              vga_vsync,
    output logic              bank_swapped,
    output logic              dbg_bank_state
);

    localparam int U_W   = $clog2(IMG_W);
    localparam int V_W   = $clog2(IMG_H);
    localparam int X_END = X0 + (IMG_W << SCALE_LOG2);
    localparam int Y_END = Y0 + (IMG_H << SCALE_LOG2);

    localparam logic [10:0] X_LO = 11'(X0);
    localparam logic [10:0] X_HI = 11'(X_END);
    localparam logic [9:0]  Y_LO = 10'(Y0);
    localparam logic [9:0]  Y_HI = 10'(Y_END);

    // Pipeline flag word: {window, border, hsync, vsync}; blank = syncs idle.
    localparam logic [3:0] BLANK = 4'b0011;

    // ------------------------------------------------------------------
    // Window / address decode (combinational on the sampled inputs)
    // ------------------------------------------------------------------
    logic [10:0]     w_x11;
    logic [9:0]      w_y10;
    logic            w_window;
    logic            w_border;
    logic [9:0]      w_dx;
    logic [8:0]      w_dy;
    logic [U_W-1:0]  w_u;
    logic [V_W-1:0]  w_v;

    assign w_x11    = {1'b0, in_x};
    assign w_y10    = {1'b0, in_y};
    assign w_window = in_active
                    && (w_x11 >= X_LO) && (w_x11 < X_HI)
                    && (w_y10 >= Y_LO) && (w_y10 < Y_HI);

    // Offsets are only meaningful inside the window; the address register
    // is zeroed elsewhere so wrap-around outside the window is harmless.
    assign w_dx = in_x - 10'(X0);
    assign w_dy = in_y - 9'(Y0);
    assign w_u  = w_dx[SCALE_LOG2 +: U_W];
    assign w_v  = w_dy[SCALE_LOG2 +: V_W];

`ifdef SCANOUT_BORDER_EN
    localparam logic [10:0] XB_LO = 11'(X0 - 1);
    localparam logic [9:0]  YB_LO = 10'(Y0 - 1);

    // Ring = window grown by one pixel on every side, minus the window.
    assign w_border = in_active && !w_window
                    && (w_x11 >= XB_LO) && (w_x11 <= X_HI)
                    && (w_y10 >= YB_LO) && (w_y10 <= Y_HI);
`else
    assign w_border = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Stage 1: RAM request + flags
    // ------------------------------------------------------------------
    logic              r_rd_en;
    logic [ADDR_W-1:0] r_rd_addr;
    logic [3:0]        r_s1;

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_en   <= 1'b0;
            r_rd_addr <= '0;
            r_s1      <= BLANK;
        end else begin
            r_rd_en   <= w_window;
            r_rd_addr <= w_window ? {w_v, w_u} : '0;
            r_s1      <= {w_window, w_border, in_hsync, in_vsync};
        end
    end

    // ------------------------------------------------------------------
    // Flag delay line covering the RAM read latency; the tail lines up
    // with rd_data.
    // ------------------------------------------------------------------
    logic [3:0] r_pipe [RAM_LAT];
    logic [3:0] w_tail;

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RAM_LAT; i++) r_pipe[i] <= BLANK;
        end else begin
            r_pipe[0] <= r_s1;
            for (int i = 1; i < RAM_LAT; i++) r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign w_tail = r_pipe[RAM_LAT-1];

    // ------------------------------------------------------------------
    // Output stage: colour select and sync registers
    // ------------------------------------------------------------------
    logic [3:0] r_rgb;
    logic       r_hs;
    logic       r_vs;

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_rgb <= 4'h0;
            r_hs  <= 1'b1;
            r_vs  <= 1'b1;
        end else begin
            if (w_tail[3])      r_rgb <= rd_data[7:4];
            else if (w_tail[2]) r_rgb <= 4'hF;
            else                r_rgb <= 4'h0;
            r_hs <= w_tail[1];
            r_vs <= w_tail[0];
        end
    end

    // ------------------------------------------------------------------
    // Bank swap FSM
    // ------------------------------------------------------------------
    typedef enum logic {S_IDLE = 1'b0, S_PENDING = 1'b1} bank_state_t;

    bank_state_t r_state;
    bank_state_t w_next;
    logic        r_vs_prev;
    logic        w_vs_fall;
    logic        w_swap;
    logic        w_wr_ready;
    logic        r_rd_bank;
    logic        r_bank_swapped;

    assign w_vs_fall = r_vs_prev && !in_vsync;

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_vs_prev      <= 1'b1;
            r_rd_bank      <= 1'b0;
            r_bank_swapped <= 1'b0;
        end else begin
            r_state        <= w_next;
            r_vs_prev      <= in_vsync;
            r_bank_swapped <= w_swap;
            if (w_swap) r_rd_bank <= ~r_rd_bank;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (frame_ready) w_next = S_PENDING;
            S_PENDING: if (w_vs_fall)   w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // frame_ready is ignored while PENDING; a frame_ready that coincides
    // with a vsync edge in IDLE waits for the following edge.
    always_comb begin
        w_wr_ready = 1'b0;
        w_swap     = 1'b0;
        case (r_state)
            S_IDLE:    w_wr_ready = 1'b1;
            S_PENDING: w_swap     = w_vs_fall;
            default:   w_wr_ready = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Output mapping
    // ------------------------------------------------------------------
    assign wr_ready       = w_wr_ready;
    assign rd_bank        = r_rd_bank;
    assign wr_bank        = ~r_rd_bank;
    assign bank_swapped   = r_bank_swapped;
    assign dbg_bank_state = r_state;
    assign rd_en          = r_rd_en;
    assign rd_addr        = r_rd_addr;
    assign vga_r          = r_rgb;
    assign vga_g          = r_rgb;
    assign vga_b          = r_rgb;
    assign vga_hsync      = r_hs;
    assign vga_vsync      = r_vs;

    // Low nibble of the pixel and the offset bits beyond the image are
    // intentionally dropped.
    logic w_unused;
    assign w_unused = ^{rd_data[3:0], w_dx, w_dy};

endmodule

// File: tb/tb_vga_image_scanout.sv
module tb_vga_image_scanout;

  localparam int ADDR_W = 14;
`ifdef SCANOUT_BORDER_EN
  localparam bit BORDER = 1'b1;
`else
  localparam bit BORDER = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic              pclk;
  logic              rst_n;
  logic              in_hsync, in_vsync, in_active;
  logic [9:0]        in_x;
  logic [8:0]        in_y;
  logic              frame_ready;
  logic              wr_ready, wr_bank, rd_en, rd_bank;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;
  logic [3:0]        vga_r, vga_g, vga_b;
  logic              vga_hsync, vga_vsync, bank_swapped, dbg_bank_state;

  initial pclk = 1'b0;
  always #20 pclk = ~pclk;

  vga_image_scanout dut (
    .pclk(pclk), .rst_n(rst_n),
    .in_hsync(in_hsync), .in_vsync(in_vsync), .in_active(in_active),
    .in_x(in_x), .in_y(in_y), .frame_ready(frame_ready),
    .wr_ready(wr_ready), .wr_bank(wr_bank), .rd_en(rd_en), .rd_bank(rd_bank),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hsync(vga_hsync), .vga_vsync(vga_vsync),
    .bank_swapped(bank_swapped), .dbg_bank_state(dbg_bank_state)
  );

  // ---------------- frame RAM (latency 1) ----------------
  logic [7:0] mem [2][16384];
  initial rd_data = 8'h00;
  always @(posedge pclk) if (rd_en) rd_data <= mem[rd_bank][rd_addr];

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [5:0] exp_q[$];   // {rgb, hsync, vsync}

  // Reference model state
  bit m_pend, m_bank, m_vs_prev;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend = 1'b0;
    m_bank = 1'b0;
    m_vs_prev = 1'b1;
    exp_q.delete();
    exp_q.push_back(6'b0000_11);
    exp_q.push_back(6'b0000_11);
  endtask

  // Drive one pixel cycle, step the clock, check everything the model knows.
  task automatic drive_cycle(input int x, input int y, input bit act,
                             input bit hs, input bit vs, input bit fr);
    bit win, ring, fall, swap;
    int addr;
    logic [7:0] pix;
    logic [3:0] col;
    logic [5:0] e;
    in_x = 10'(x); in_y = 9'(y); in_active = act;
    in_hsync = hs; in_vsync = vs; frame_ready = fr;
    win  = act && x >= 192 && x < 192 + 256 && y >= 112 && y < 112 + 256;
    ring = BORDER && act && !win && x >= 191 && x <= 448 && y >= 111 && y <= 368;
    addr = ((y - 112) / 2) * 128 + (x - 192) / 2;
    fall = m_vs_prev && !vs;
    swap = m_pend && fall;
    if (m_pend) begin
      if (fall) m_pend = 1'b0;
    end else if (fr) begin
      m_pend = 1'b1;
    end
    if (swap) m_bank = ~m_bank;
    m_vs_prev = vs;
    @(posedge pclk); #1;
    check("rd_en", rd_en, win);
    if (win) check("rd_addr", rd_addr, addr);
    check("wr_ready", wr_ready, !m_pend);
    check("dbg_state", dbg_bank_state, m_pend);
    check("rd_bank", rd_bank, m_bank);
    check("wr_bank", wr_bank, !m_bank);
    check("bank_swapped", bank_swapped, swap);
    if (win) begin
      pix = mem[m_bank][addr];
      col = pix[7:4];
    end else if (ring) col = 4'hF;
    else col = 4'h0;
    exp_q.push_back({col, hs, vs});
    if (exp_q.size() >= 3) begin
      e = exp_q.pop_front();
      check("vga_r", vga_r, e[5:2]);
      check("vga_g", vga_g, e[5:2]);
      check("vga_b", vga_b, e[5:2]);
      check("vga_hsync", vga_hsync, e[1]);
      check("vga_vsync", vga_vsync, e[0]);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(0, 0, 1'b0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rgb"}, {vga_r, vga_g, vga_b}, 12'h000);
    check({tag, "_hs"}, vga_hsync, 1'b1);
    check({tag, "_vs"}, vga_vsync, 1'b1);
    check({tag, "_rd_bank"}, rd_bank, 1'b0);
    check({tag, "_wr_ready"}, wr_ready, 1'b1);
    check({tag, "_rd_en"}, rd_en, 1'b0);
    check({tag, "_rd_addr"}, rd_addr, 0);
    check({tag, "_swapped"}, bank_swapped, 1'b0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int x; int y; bit act;
    bit exp_en; int exp_addr; int kind;   // kind: 0 black, 1 pixel, 2 ring
  } vec_t;
  vec_t tbl[15];

  initial begin
    int first_low, width;
    bit vs_r;
    logic [7:0] pb;
    logic [3:0] want;

    tbl[0]  = '{192, 112, 1'b1, 1'b1, 0,     1};
    tbl[1]  = '{193, 112, 1'b1, 1'b1, 0,     1};
    tbl[2]  = '{194, 112, 1'b1, 1'b1, 1,     1};
    tbl[3]  = '{192, 114, 1'b1, 1'b1, 128,   1};
    tbl[4]  = '{447, 367, 1'b1, 1'b1, 16383, 1};
    tbl[5]  = '{191, 112, 1'b1, 1'b0, 0,     2};
    tbl[6]  = '{448, 112, 1'b1, 1'b0, 0,     2};
    tbl[7]  = '{191, 150, 1'b1, 1'b0, 0,     2};
    tbl[8]  = '{448, 150, 1'b1, 1'b0, 0,     2};
    tbl[9]  = '{300, 111, 1'b1, 1'b0, 0,     2};
    tbl[10] = '{300, 368, 1'b1, 1'b0, 0,     2};
    tbl[11] = '{191, 111, 1'b1, 1'b0, 0,     2};
    tbl[12] = '{449, 150, 1'b1, 1'b0, 0,     0};
    tbl[13] = '{300, 110, 1'b1, 1'b0, 0,     0};
    tbl[14] = '{300, 200, 1'b0, 1'b0, 0,     0};

    for (int b = 0; b < 2; b++)
      for (int a = 0; a < 16384; a++) mem[b][a] = 8'($urandom_range(255, 0));
    mem[0][0] = 8'hA5;
    mem[1][0] = 8'h5A;
    mem[0][16383] = 8'h3C;

    // ---- reset ----
    rst_n = 1'b0;
    in_x = '0; in_y = '0; in_active = 1'b0;
    in_hsync = 1'b1; in_vsync = 1'b1; frame_ready = 1'b0;
    repeat (3) @(posedge pclk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    model_reset();

    // ---- table-driven addressing / colour / border ----
    for (int i = 0; i < 15; i++) begin
      drive_cycle(tbl[i].x, tbl[i].y, tbl[i].act, 1'b1, 1'b1, 1'b0);
      check("tbl_rd_en", rd_en, tbl[i].exp_en);
      if (tbl[i].exp_en) check("tbl_rd_addr", rd_addr, tbl[i].exp_addr);
      idle(2);
      if (tbl[i].kind == 1) begin
        pb = mem[0][tbl[i].exp_addr];
        want = pb[7:4];
      end else if (tbl[i].kind == 2) want = BORDER ? 4'hF : 4'h0;
      else want = 4'h0;
      check("tbl_rgb", vga_r, want);
    end

    // ---- latency: pixel A5 appears exactly 3 cycles later ----
    drive_cycle(192, 112, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(1);
    check("lat_early", vga_r, 4'h0);
    idle(1);
    check("lat_r", vga_r, 4'hA);
    check("lat_b", vga_b, 4'hA);
    idle(1);
    check("lat_after", vga_r, 4'h0);

    // ---- hsync pulse: 96 wide, delayed 3 cycles ----
    first_low = -1;
    width = 0;
    for (int c = 0; c < 120; c++) begin
      drive_cycle(300, 200, 1'b0, !(c >= 5 && c < 101), 1'b1, 1'b0);
      if (vga_hsync == 1'b0) begin
        if (first_low < 0) first_low = c;
        width++;
      end
    end
    check("hs_start", first_low, 7);
    check("hs_width", width, 96);

    // ---- bank swap handshake ----
    drive_cycle(200, 120, 1'b1, 1'b1, 1'b1, 1'b1);
    check("swap_wr_ready_low", wr_ready, 1'b0);
    drive_cycle(201, 120, 1'b1, 1'b1, 1'b1, 1'b0);
    drive_cycle(202, 120, 1'b1, 1'b1, 1'b1, 1'b1);   // ignored while pending
    idle(3);
    check("swap_not_yet", rd_bank, 1'b0);
    drive_cycle(0, 0, 1'b0, 1'b1, 1'b0, 1'b0);       // vsync fall
    check("swap_bank", rd_bank, 1'b1);
    check("swap_pulse", bank_swapped, 1'b1);
    check("swap_wr_ready", wr_ready, 1'b1);
    drive_cycle(0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("swap_pulse_end", bank_swapped, 1'b0);
    idle(4);
    check("swap_no_extra", rd_bank, 1'b1);
    drive_cycle(192, 112, 1'b1, 1'b1, 1'b1, 1'b0);   // reads new front bank
    idle(2);
    check("swap_pixel", vga_r, 4'h5);
    // frame_ready coincident with vsync fall in IDLE: waits a frame
    drive_cycle(0, 0, 1'b0, 1'b1, 1'b0, 1'b1);
    check("coinc_no_swap", bank_swapped, 1'b0);
    check("coinc_pending", wr_ready, 1'b0);
    idle(5);
    drive_cycle(0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("coinc_swap", rd_bank, 1'b0);
    check("coinc_pulse", bank_swapped, 1'b1);
    idle(2);

    // ---- reset mid-PENDING, mid-line ----
    drive_cycle(0, 0, 1'b0, 1'b1, 1'b1, 1'b1);
    idle(2);
    drive_cycle(0, 0, 1'b0, 1'b1, 1'b0, 1'b0);       // bank -> 1
    idle(2);
    drive_cycle(0, 0, 1'b0, 1'b1, 1'b1, 1'b1);       // pending again
    drive_cycle(192, 112, 1'b1, 1'b0, 1'b1, 1'b0);
    drive_cycle(193, 112, 1'b1, 1'b0, 1'b1, 1'b0);
    drive_cycle(194, 112, 1'b1, 1'b0, 1'b1, 1'b0);   // vga shows pixel, hs low
    check("pre_reset_bank", rd_bank, 1'b1);
    #4;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    in_x = '0; in_y = '0; in_active = 1'b0; in_hsync = 1'b1; in_vsync = 1'b1;
    @(posedge pclk); #1;
    check_reset_outputs("held_reset");
    rst_n = 1'b1;
    model_reset();
    idle(3);
    drive_cycle(0, 0, 1'b0, 1'b1, 1'b0, 1'b0);       // vsync fall, nothing pending
    check("post_reset_no_swap", bank_swapped, 1'b0);
    check("post_reset_bank", rd_bank, 1'b0);
    idle(3);

    // ---- randomized run against the model ----
    vs_r = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(31, 0) == 0) vs_r = ~vs_r;
      drive_cycle($urandom_range(455, 185), $urandom_range(375, 105),
                  $urandom_range(7, 0) != 0, $urandom_range(15, 0) != 0,
                  vs_r, $urandom_range(39, 0) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_image_scanout.md
# vga_image_scanout

Pixel-fetch and colour stage directly downstream of the 640x480 VGA sync generator. Takes the generator's registered coordinates and sync pulses, fetches grayscale pixels of the filtered image from a double-banked frame RAM, scales and centres the image on screen, and drives pipeline-aligned RGB plus sync to the VGA pins. Owns the front/back bank swap handshake with the upstream Wiener filter writer, so a new frame never tears.

## Interface
- IMG_W, 128: image width in pixels, power of two
- IMG_H, 128: image height in pixels, power of two
- SCALE_LOG2, 1: pixel replication factor 2^SCALE_LOG2 in x and y
- X0, 192: left screen column of image window, must be ≥1
- Y0, 112: top screen row of image window, must be ≥1
- ADDR_W, 14: log2(IMG_W*IMG_H)
- RAM_LAT, 1: frame RAM read latency in cycles, 1 or 2

- pclk  in  1  pixel clock, 25 MHz
- rst_n  in  1  asynchronous, active-low reset
- in_hsync, in_vsync  in  1  active-low syncs from sync generator
- in_active  in  1  visible-area flag, aligned with in_x/in_y
- in_x  in  10  column 0..639
- in_y  in  9  row 0..479
- frame_ready  in  1  one-cycle pulse: writer finished a frame in back bank
- wr_ready  out  1  writer may fill back bank and pulse frame_ready
- wr_bank  out  1  back bank index (= ~rd_bank)
- rd_en  out  1  frame RAM read enable
- rd_bank  out  1  front bank index
- rd_addr  out  ADDR_W  frame RAM address, row-major
- rd_data  in  8  grayscale pixel, valid RAM_LAT cycles after rd_en
- vga_r, vga_g, vga_b  out  4  colour outputs
- vga_hsync, vga_vsync  out  1  syncs delayed to match colour
- bank_swapped  out  1  one-cycle pulse when front bank toggles

## Operation
- Window: x in [X0, X0+(IMG_W<<SCALE_LOG2)), y in [Y0, Y0+(IMG_H<<SCALE_LOG2)), and in_active=1.
- u=(x−X0)>>SCALE_LOG2, v=(y−Y0)>>SCALE_LOG2; rd_addr={v,u} (v*IMG_W+u); rd_en=1 only in window.
- Colour: in window, r=g=b=rd_data[7:4]; all other cycles 0.
- Bank FSM, states IDLE, PENDING:
  - IDLE: wr_ready=1; frame_ready → PENDING.
  - PENDING: wr_ready=0; frame_ready ignored; on in_vsync falling edge (1→0 between consecutive samples) rd_bank toggles, bank_swapped=1 for one cycle, → IDLE.
  - frame_ready in the same cycle as the vsync edge while IDLE: enter PENDING; swap occurs at next frame's edge.
- Swap never occurs mid-frame; rd_bank stable from vsync edge to vsync edge.
- Reset (asynchronous, any time, including mid-line): state IDLE, rd_bank=0, wr_ready=1, rd_en=0, rd_addr=0, RGB=0, vga_hsync=vga_vsync=1, bank_swapped=0, all pipeline stages cleared to blank/sync-inactive.

## Timing
- Inputs sampled at cycle t; rd_addr/rd_en registered at t+1; rd_data consumed at t+1+RAM_LAT; RGB and syncs registered at t+2+RAM_LAT.
- Total latency L=RAM_LAT+2 for colour, hsync, vsync and window flag alike; all remain mutually aligned.
- One pixel per clock, no stalls, no backpressure.
- bank_swapped asserted the cycle after the vsync edge is sampled; rd_bank changes in that same cycle.

## Configuration
- SCANOUT_BORDER_EN defined: one-pixel ring immediately outside the window (x=X0−1 or x=X0+(IMG_W<<SCALE_LOG2) on window rows, including corners; same for rows) drives r=g=b=4'hF with same latency L; rd_en=0 there.
- Not defined: ring pixels are black; no border logic synthesised.

## Test plan
- Reset: hold rst_n=0 mid-line → next pclk edge not required, outputs immediately RGB=0, syncs=1, rd_bank=0, wr_ready=1.
- Addressing, defaults: (x,y)=(192,112)→rd_addr 0; (193,112)→0; (194,112)→1; (192,114)→128; (447,367)→16383; (191,112) and (448,112)→rd_en=0.
- Latency: rd_data=8'hA5 for in-window pixel, RAM_LAT=1 → vga_r/g/b=4'hA exactly 3 cycles after input; in_hsync low pulse appears on vga_hsync 3 cycles later, same width 96.
- Bank swap: frame_ready pulse mid-frame → wr_ready=0 next cycle; at following vsync fall rd_bank 0→1, bank_swapped one cycle, wr_ready=1; second frame_ready while PENDING → no extra swap.
- Border (macro on): (191,150) and (448,150), (300,111), (300,368) → RGB 4'hF; macro off → 0.
- Reset asserted mid-PENDING → IDLE, rd_bank=0, no bank_swapped at next vsync.
